// File: rtl/mp_ram_pkg.sv
// Shared definitions for the multi-port bypass RAM.
//   state_t     : clear FSM state encoding (idle / clearing).
//   LatBase     : read latency without the output stage.
//   LatOutReg   : read latency with the extra output stage.
//   rd_latency  : maps the OUT_REG parameter to the resulting read latency.
package mp_ram_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StClear = 1'b1
  } state_t;

  localparam int unsigned LatBase   = 1;
  localparam int unsigned LatOutReg = 2;

  function automatic int unsigned rd_latency(input int unsigned out_reg);
    return (out_reg != 0) ? LatOutReg : LatBase;
  endfunction

endpackage

// File: rtl/mp_ram_bank.sv
// Storage array with one byte-strobed write port and NRD asynchronous read ports.
// Carries no reset so it maps onto RAM primitives. Out-of-range writes are
// dropped and out-of-range reads return zero.
//   clk      : clock
//   i_we     : write enable
//   i_addr   : write address
//   i_strb   : byte enables for the write
//   i_data   : write data
//   i_raddr  : packed read addresses, port p in slice p
//   o_rdata  : packed read data, port p in slice p
module mp_ram_bank #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 12,
  parameter int unsigned MEM_NUM = 4096,
  parameter int unsigned NRD     = 2
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DW/8-1:0]   i_strb,
  input  logic [DW-1:0]     i_data,
  input  logic [NRD*AW-1:0] i_raddr,
  output logic [NRD*DW-1:0] o_rdata
);

  localparam int unsigned NB = DW / 8;
  // Index width that exactly covers the array; upper address bits only matter
  // for the range check.
  localparam int unsigned IW = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;

  logic [DW-1:0] r_mem [MEM_NUM];

  logic w_wr_in_range;
  assign w_wr_in_range = 32'(i_addr) < MEM_NUM;

  always_ff @(posedge clk) begin
    if (i_we && w_wr_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (i_strb[b]) begin
          r_mem[i_addr[IW-1:0]][b*8 +: 8] <= i_data[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int p = 0; p < NRD; p++) begin
      if (32'(i_raddr[p*AW +: AW]) < MEM_NUM) begin
        o_rdata[p*DW +: DW] = r_mem[i_raddr[p*AW +: IW]];
      end
    end
  end

endmodule

// File: rtl/mp_ram_bypass.sv
// Multi-read-port RAM with per-byte write-to-read bypass, optional output stage
// and a hardware clear engine that zeroes one word per cycle.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset; starts a full clear
//   wen        : write request
//   w_addr_i   : write address
//   w_strb_i   : byte enables, bit k covers data bits 8k+7..8k
//   w_data_i   : write data
//   ren        : read request per port
//   r_addr_i   : packed read addresses
//   r_data_o   : packed read data, held between completions
//   r_valid_o  : per-port pulse marking new r_data_o
//   clr_i      : request to clear the whole array
//   busy_o     : high while clearing; requests are ignored then
module mp_ram_bypass
  import mp_ram_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 12,
  parameter int unsigned MEM_NUM = 4096,
  parameter int unsigned NRD     = 2,
  parameter int unsigned OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [AW-1:0]     w_addr_i,
  input  logic [DW/8-1:0]   w_strb_i,
  input  logic [DW-1:0]     w_data_i,
  input  logic [NRD-1:0]    ren,
  input  logic [NRD*AW-1:0] r_addr_i,
  output logic [NRD*DW-1:0] r_data_o,
  output logic [NRD-1:0]    r_valid_o,
  input  logic              clr_i,
  output logic              busy_o
);

  localparam int unsigned NB       = DW / 8;
  localparam int unsigned RdLat    = rd_latency(OUT_REG);
  localparam bit          UseStage = (RdLat == LatOutReg);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_clr_ptr, w_clr_ptr_nxt;
  logic          w_busy;
  logic          w_can_accept;
  logic          w_wr_acc;

  assign w_busy       = (r_state == StClear);
  assign busy_o       = w_busy;
  // Reset dominates any request presented in the same cycle.
  assign w_can_accept = !w_busy && !rst;
  assign w_wr_acc     = wen && w_can_accept && (32'(w_addr_i) < MEM_NUM);

  // Clear FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StClear;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    unique case (r_state)
      StIdle: begin
        if (clr_i) begin
          w_state_nxt   = StClear;
          w_clr_ptr_nxt = '0;
        end
      end
      StClear: begin
        if (r_clr_ptr == AW'(MEM_NUM - 1)) begin
          w_state_nxt = StIdle;
        end else begin
          w_clr_ptr_nxt = r_clr_ptr + AW'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // The clear engine owns the single write port while busy.
  logic            w_bank_we;
  logic [AW-1:0]   w_bank_addr;
  logic [NB-1:0]   w_bank_strb;
  logic [DW-1:0]   w_bank_data;
  logic [NRD*DW-1:0] w_bank_rdata;

  assign w_bank_we   = w_busy ? !rst : w_wr_acc;
  assign w_bank_addr = w_busy ? r_clr_ptr : w_addr_i;
  assign w_bank_strb = w_busy ? '1 : w_strb_i;
  assign w_bank_data = w_busy ? '0 : w_data_i;

  mp_ram_bank #(
    .DW      (DW),
    .AW      (AW),
    .MEM_NUM (MEM_NUM),
    .NRD     (NRD)
  ) u_bank (
    .clk     (clk),
    .i_we    (w_bank_we),
    .i_addr  (w_bank_addr),
    .i_strb  (w_bank_strb),
    .i_data  (w_bank_data),
    .i_raddr (r_addr_i),
    .o_rdata (w_bank_rdata)
  );

  // Read acceptance and per-byte bypass of a same-cycle write. w_wr_acc is
  // only set for in-range addresses, so out-of-range reads stay zero.
  logic [NRD-1:0]    w_rd_acc;
  logic [NRD*DW-1:0] w_rd_data;

  always_comb begin
    w_rd_acc  = '0;
    w_rd_data = w_bank_rdata;
    for (int p = 0; p < NRD; p++) begin
      w_rd_acc[p] = ren[p] && w_can_accept;
      if (w_wr_acc && (w_addr_i == r_addr_i[p*AW +: AW])) begin
        for (int b = 0; b < NB; b++) begin
          if (w_strb_i[b]) begin
            w_rd_data[p*DW + b*8 +: 8] = w_data_i[b*8 +: 8];
          end
        end
      end
    end
  end

  // Optional stage capturing the data seen at acceptance; it keeps advancing
  // during a clear so reads already in flight still complete.
  logic [NRD-1:0]    w_st_valid;
  logic [NRD*DW-1:0] w_st_data;

  if (UseStage) begin : g_stage
    logic [NRD-1:0]    r_s1_valid;
    logic [NRD*DW-1:0] r_s1_data;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1_valid <= '0;
      end else begin
        r_s1_valid <= w_rd_acc;
      end
    end

    always_ff @(posedge clk) begin
      r_s1_data <= w_rd_data;
    end

    assign w_st_valid = r_s1_valid;
    assign w_st_data  = r_s1_data;
  end else begin : g_direct
    assign w_st_valid = w_rd_acc;
    assign w_st_data  = w_rd_data;
  end

  // Output register; each slice holds until its port completes a read.
  logic [NRD-1:0]    r_out_valid;
  logic [NRD*DW-1:0] r_out_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= '0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_st_valid;
      for (int p = 0; p < NRD; p++) begin
        if (w_st_valid[p]) begin
          r_out_data[p*DW +: DW] <= w_st_data[p*DW +: DW];
        end
      end
    end
  end

  assign r_valid_o = r_out_valid;
  assign r_data_o  = r_out_data;

endmodule

// File: tb/tb_mp_ram_bypass.sv
module tb_mp_ram_bypass;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned MN = 16;
  localparam int unsigned NR = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wen;
  logic [AW-1:0] w_addr;
  logic [3:0]    w_strb;
  logic [31:0]   w_data;
  logic [1:0]    ren;
  logic [9:0]    r_addr;
  logic          clr;

  logic [63:0] rd0, rd1;
  logic [1:0]  rv0, rv1;
  logic        busy0, busy1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mp_ram_bypass #(.DW(DW), .AW(AW), .MEM_NUM(MN), .NRD(NR), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .wen(wen), .w_addr_i(w_addr), .w_strb_i(w_strb),
    .w_data_i(w_data), .ren(ren), .r_addr_i(r_addr), .r_data_o(rd0),
    .r_valid_o(rv0), .clr_i(clr), .busy_o(busy0)
  );

  mp_ram_bypass #(.DW(DW), .AW(AW), .MEM_NUM(MN), .NRD(NR), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .wen(wen), .w_addr_i(w_addr), .w_strb_i(w_strb),
    .w_data_i(w_data), .ren(ren), .r_addr_i(r_addr), .r_data_o(rd1),
    .r_valid_o(rv1), .clr_i(clr), .busy_o(busy1)
  );

  // Reference model: memory image, clear progress and expected outputs for
  // latency 1 (e0_*) and latency 2 (s1_* in flight, e1_* visible).
  logic [31:0] m_mem [MN];
  bit          m_clear = 1'b0;
  int          m_ptr = 0;
  logic [63:0] e0_data = '0, s1_data = '0, e1_data = '0;
  logic [1:0]  e0_valid = '0, s1_valid = '0, e1_valid = '0;

  task automatic model_edge();
    logic [31:0] rd [2];
    logic [1:0]  acc;
    int          a;
    if (rst) begin
      m_clear = 1'b1;
      m_ptr = 0;
      e0_data = '0; e0_valid = '0;
      e1_data = '0; e1_valid = '0;
      s1_valid = '0;
      return;
    end
    acc = '0;
    rd[0] = '0;
    rd[1] = '0;
    if (!m_clear) begin
      for (int p = 0; p < 2; p++) begin
        if (ren[p]) begin
          acc[p] = 1'b1;
          a = int'(r_addr[p*AW +: AW]);
          if (a < MN) begin
            rd[p] = m_mem[a];
            if (wen && int'(w_addr) == a)
              for (int b = 0; b < 4; b++) if (w_strb[b]) rd[p][b*8 +: 8] = w_data[b*8 +: 8];
          end
        end
      end
      if (wen && int'(w_addr) < MN)
        for (int b = 0; b < 4; b++) if (w_strb[b]) m_mem[w_addr][b*8 +: 8] = w_data[b*8 +: 8];
      if (clr) begin
        m_clear = 1'b1;
        m_ptr = 0;
      end
    end else begin
      m_mem[m_ptr] = '0;
      if (m_ptr == MN - 1) m_clear = 1'b0;
      else m_ptr++;
    end
    e1_valid = s1_valid;
    for (int p = 0; p < 2; p++) if (s1_valid[p]) e1_data[p*32 +: 32] = s1_data[p*32 +: 32];
    s1_valid = acc;
    for (int p = 0; p < 2; p++) if (acc[p]) s1_data[p*32 +: 32] = rd[p];
    e0_valid = acc;
    for (int p = 0; p < 2; p++) if (acc[p]) e0_data[p*32 +: 32] = rd[p];
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: apply current inputs, advance model, compare at the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("busy0", 64'(busy0), 64'(m_clear));
    chk("busy1", 64'(busy1), 64'(m_clear));
    chk("valid0", 64'(rv0), 64'(e0_valid));
    chk("data0", rd0, e0_data);
    chk("valid1", 64'(rv1), 64'(e1_valid));
    chk("data1", rd1, e1_data);
  endtask

  task automatic idle();
    wen = 1'b0; w_addr = '0; w_strb = '0; w_data = '0;
    ren = '0; r_addr = '0; clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();

    // Reset for 3 cycles, then a full clear of 16 cycles.
    for (int i = 0; i < 3; i++) cyc();
    chk("rst_busy", 64'(busy0), 64'd1);
    chk("rst_valid", 64'({rv1, rv0}), 64'd0);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      if (i == 15) chk("rst_clear_busy15", 64'(busy0), 64'd1);
    end
    chk("rst_clear_done", 64'({busy1, busy0}), 64'd0);

    for (int i = 0; i < 16; i++) begin
      ren = 2'b11;
      r_addr = {5'(15 - i), 5'(i)};
      cyc();
      chk("clear_read0", rd0, 64'd0);
    end
    idle();
    cyc();

    // Byte strobes.
    wen = 1'b1; w_addr = 5'd5; w_strb = 4'b1111; w_data = 32'h11223344;
    cyc();
    w_strb = 4'b0101; w_data = 32'hAABBCCDD;
    cyc();
    idle();
    ren = 2'b01; r_addr = {5'd0, 5'd5};
    cyc();
    chk("strb_data0", 64'(rd0[31:0]), 64'h11BB33DD);
    idle();
    cyc();
    chk("strb_data1", 64'(rd1[31:0]), 64'h11BB33DD);
    chk("strb_valid1", 64'(rv1), 64'd1);

    // Same-cycle write/read bypass on both ports.
    wen = 1'b1; w_addr = 5'd7; w_strb = 4'b0011; w_data = 32'hDEADBEEF;
    ren = 2'b11; r_addr = {5'd7, 5'd7};
    cyc();
    chk("bypass_valid0", 64'(rv0), 64'd3);
    chk("bypass_data0", rd0, {2{32'h0000BEEF}});
    // Write in the following cycle must not reach the staged result.
    idle();
    wen = 1'b1; w_addr = 5'd7; w_strb = 4'b1111; w_data = 32'h12345678;
    cyc();
    chk("bypass_valid1", 64'(rv1), 64'd3);
    chk("bypass_data1", rd1, {2{32'h0000BEEF}});
    idle();
    cyc();

    // Clear request: reads ignored, second clr_i ignored, 16 busy cycles.
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    ren = 2'b11; r_addr = {5'd7, 5'd5};
    for (int i = 1; i <= 16; i++) begin
      clr = (i == 4);
      cyc();
      chk("clr_no_valid", 64'({rv1, rv0}), 64'd0);
      if (i == 15) chk("clr_busy15", 64'(busy0), 64'd1);
    end
    chk("clr_done", 64'(busy0), 64'd0);
    clr = 1'b0;
    cyc();
    cyc();
    idle();

    // Out-of-range write/read.
    wen = 1'b1; w_addr = 5'd20; w_strb = 4'b1111; w_data = 32'hFFFFFFFF;
    cyc();
    idle();
    ren = 2'b11; r_addr = {5'd4, 5'd20};
    cyc();
    chk("oor_valid0", 64'(rv0), 64'd3);
    chk("oor_data0", rd0, 64'd0);
    idle();
    cyc();

    // Clear with reads in flight, then reset in the middle of it.
    clr = 1'b1; ren = 2'b11; r_addr = {5'd5, 5'd7};
    cyc();
    idle();
    cyc();
    chk("inflight_valid1", 64'(rv1), 64'd3);
    for (int i = 0; i < 6; i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      if (i == 15) chk("midrst_busy15", 64'(busy1), 64'd1);
    end
    chk("midrst_done", 64'(busy1), 64'd0);

    // Randomized traffic, biased toward a few addresses to hit the bypass.
    for (int i = 0; i < 600; i++) begin
      wen    = ($urandom_range(0, 1) == 1);
      w_addr = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 19) : $urandom_range(0, 3));
      w_strb = 4'($urandom);
      w_data = $urandom;
      ren    = 2'($urandom);
      r_addr = {5'($urandom_range(0, 19)), 5'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1) r_addr[9:5] = w_addr;
      clr    = ($urandom_range(0, 79) == 0);
      rst    = ($urandom_range(0, 249) == 0);
      cyc();
    end
    rst = 1'b0;
    idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
